updown_sweep_ctrl: RTL

//   Sequencer for the 5-bit up/down counter datapath. Drives the count direction (mode)
//   and sweeps dout as a triangle between programmable bounds lo..hi..lo, repeated N times.

---
 rtl/updown_pkg.sv | 13 +
 rtl/updown_cnt_core.sv | 25 ++
 rtl/updown_sweep_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared widths and state encoding for the up/down sweep sequencer
package updown_pkg;

    localparam int WIDTH   = 5;
    localparam int SWEEP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/updown_cnt_core.sv
// rtl/updown_cnt_core.sv - loadable up/down counter register with step enable
module updown_cnt_core #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] dout
);

    // load has priority so a new run can start from any frozen value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else if (load) begin
            dout <= load_val;
        end else if (en) begin
            dout <= mode ? dout + 1'b1 : dout - 1'b1;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - triangle sweep sequencer driving the up/down counter core
import updown_pkg::*;

module updown_sweep_ctrl #(
    parameter int WIDTH   = updown_pkg::WIDTH,
    parameter int SWEEP_W = updown_pkg::SWEEP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [WIDTH-1:0]   dout,
    output logic               mode,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    state_t               state;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_q;
    logic [SWEEP_W-1:0]   num_q;
    logic [SWEEP_W-1:0]   sweep_cnt;

    logic                 start_ok;
    logic                 step_en;
    logic                 at_hi;
    logic                 at_lo;
    logic [SWEEP_W-1:0]   sweep_next;
    logic                 last_sweep;
    logic [WIDTH-1:0]     dout_inc;
    logic [WIDTH-1:0]     dout_dec;

    assign start_ok   = (state == ST_IDLE) && start && !abort && (lo_bound < hi_bound);
    assign step_en    = (state != ST_IDLE) && !hold && !abort;
    // turn points are detected on the value being stepped to, so the turn lands on that same edge
    assign dout_inc   = dout + 1'b1;
    assign dout_dec   = dout - 1'b1;
    assign at_hi      = (dout_inc == hi_q);
    assign at_lo      = (dout_dec == lo_q);
    assign sweep_next = sweep_cnt + 1'b1;
    // num_q == 0 means free-running; the counter then just wraps
    assign last_sweep = (num_q != '0) && (sweep_next == num_q);

    updown_cnt_core #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_ok),
        .load_val (lo_bound),
        .en       (step_en),
        .mode     (state == ST_UP),
        .dout     (dout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mode      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            num_q     <= '0;
            sweep_cnt <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (lo_bound < hi_bound) begin
                            lo_q      <= lo_bound;
                            hi_q      <= hi_bound;
                            num_q     <= num_sweeps;
                            sweep_cnt <= '0;
                            mode      <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_UP;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        mode  <= 1'b1;
                    end else if (!hold && at_hi) begin
                        mode  <= 1'b0;
                        state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        mode  <= 1'b1;
                    end else if (!hold && at_lo) begin
                        sweep_cnt <= sweep_next;
                        mode      <= 1'b1;
                        if (last_sweep) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_UP;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    mode  <= 1'b1;
                end
            endcase
        end
    end

endmodule
